countdown_timer: RTL and testbench

Programmable down-counter, the complement of the free-running 20-bit up-counter.
- A producer loads a start value through a valid/ready handshake.
- The block decrements once per prescaled tick, pulses done on reaching zero, then either stops or auto-reloads.
- It sits beside the up-counter as the timeout/interval source for control FSMs in the same clock domain.

---
 rtl/countdown_timer_pkg.sv | 23 ++
 rtl/countdown_timer_if.sv | 27 ++
 rtl/countdown_timer_tick_gen.sv | 36 +++
 rtl/countdown_timer.sv | 98 +++++++++
 tb/tb_countdown_timer.sv | 343 ++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/countdown_timer_pkg.sv
// Shared types and helpers for the countdown timer slice.
package countdown_timer_pkg;

    // Controller state: waiting for a load, or counting down.
    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    localparam int DEFAULT_WIDTH = 20;

    // Bits needed to hold 0..value-1, never less than one bit so a
    // divide-by-one prescaler still has a legal counter declaration.
    function automatic int clog2_min1(input int value);
        int w;
        w = 0;
        while ((1 << w) < value) begin
            w++;
        end
        return (w < 1) ? 1 : w;
    endfunction

endpackage

// File: rtl/countdown_timer_if.sv
// Load handshake, run controls and count status shared by a producer
// (master) and the countdown timer (slave).
interface countdown_timer_if
    import countdown_timer_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
);
    logic             load_valid;
    logic             load_ready;
    logic [WIDTH-1:0] load_value;
    logic             reload_en;
    logic             pause;
    logic             abort;
    logic [WIDTH-1:0] out;
    logic             busy;
    logic             done;

    modport master (
        output load_valid, load_value, reload_en, pause, abort,
        input  load_ready, out, busy, done
    );

    modport slave (
        input  load_valid, load_value, reload_en, pause, abort,
        output load_ready, out, busy, done
    );
endinterface

// File: rtl/countdown_timer_tick_gen.sv
// Prescale divider: one-cycle tick every PRESCALE enabled clocks.
// The phase counter freezes while en is low and restarts from zero on clr.
module countdown_timer_tick_gen
    import countdown_timer_pkg::*;
#(
    parameter int PRESCALE = 1
) (
    input  logic clk,
    input  logic rstn,
    input  logic en,
    input  logic clr,
    output logic tick
);
    localparam int            CW   = clog2_min1(PRESCALE);
    localparam logic [CW-1:0] LAST = CW'(PRESCALE - 1);

    logic [CW-1:0] phase;

    // Tick on the last phase of an enabled cycle; the owner decides priority
    // against abort, so clr does not gate it here.
    assign tick = en && (phase == LAST);

    // Advance the phase counter while enabled, wrapping after the last phase.
    always_ff @(posedge clk or negedge rstn) begin
        // NOTE: state registers use <= so every flop samples pre-edge values;
        // a blocking = here would let later statements see the new value.
        if (!rstn) begin
            phase <= '0;
        end else if (clr) begin
            phase <= '0;
        end else if (en) begin
            phase <= (phase == LAST) ? '0 : phase + 1'b1;
        end
    end

endmodule

// File: rtl/countdown_timer.sv
// Programmable down-counter: accepts a start value over a valid/ready
// handshake, decrements once per prescaled tick, pulses done at expiry and
// then stops or reloads the last accepted value.
module countdown_timer
    import countdown_timer_pkg::*;
#(
    parameter int WIDTH    = DEFAULT_WIDTH,
    parameter int PRESCALE = 1
) (
    input logic              clk,
    input logic              rstn,
    countdown_timer_if.slave bus
);
    state_t           state;
    logic [WIDTH-1:0] count;
    logic [WIDTH-1:0] reload_reg;
    logic             done_q;

    logic accept;
    logic tick;
    logic tick_en;
    logic tick_clr;

    // Loads are only taken while idle, and an abort held in IDLE blocks them.
    assign bus.load_ready = (state == IDLE) && !bus.abort;
    assign accept         = bus.load_valid && bus.load_ready;

    // Prescaler runs only while counting and not paused; a fresh load or an
    // abort restarts its phase so every count begins with a full period.
    assign tick_en  = (state == RUN) && !bus.pause;
    assign tick_clr = accept || ((state == RUN) && bus.abort);

    countdown_timer_tick_gen #(
        .PRESCALE (PRESCALE)
    ) u_tick_gen (
        .clk  (clk),
        .rstn (rstn),
        .en   (tick_en),
        .clr  (tick_clr),
        .tick (tick)
    );

    // Controller: load handling, abort/pause/tick priority and expiry.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state      <= IDLE;
            count      <= '0;
            reload_reg <= '0;
            done_q     <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state)
                IDLE: begin
                    if (accept) begin
                        if (bus.load_value != '0) begin
                            count      <= bus.load_value;
                            reload_reg <= bus.load_value;
                            state      <= RUN;
                        end else begin
                            // A zero load expires immediately without running.
                            count  <= '0;
                            done_q <= 1'b1;
                        end
                    end
                end
                RUN: begin
                    if (bus.abort) begin
                        count <= '0;
                        state <= IDLE;
                    end else if (tick) begin
                        // Pause needs no branch: it already holds tick low.
                        if (count > WIDTH'(1)) begin
                            count <= count - 1'b1;
                        end else begin
                            // Last unit consumed: expire instead of reaching 0
                            // by decrement, so the count never wraps.
                            done_q <= 1'b1;
                            if (bus.reload_en) begin
                                count <= reload_reg;
                            end else begin
                                count <= '0;
                                state <= IDLE;
                            end
                        end
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    assign bus.out  = count;
    assign bus.busy = (state == RUN);
    assign bus.done = done_q;

endmodule

// File: tb/tb_countdown_timer.sv
// Bench for countdown_timer: two instances (PRESCALE 1 and 4) share one
// stimulus stream. A cycle-budget model tracks the remaining time of each
// instance in clock cycles; expected done pulses go into per-instance
// queues that a negedge monitor drains whenever a DUT raises done.
module tb_countdown_timer;
    import countdown_timer_pkg::*;

    localparam int W   = 20;
    localparam int P_A = 1;
    localparam int P_B = 4;

    typedef struct {
        int             stamp;
        logic [W-1:0]   out;
    } exp_t;

    logic           clk = 1'b0;
    logic           rstn = 1'b0;
    logic           load_valid = 1'b0;
    logic [W-1:0]   load_value = '0;
    logic           reload_en = 1'b0;
    logic           pause = 1'b0;
    logic           abort = 1'b0;

    int total = 0;
    int bad   = 0;
    int cycle = 0;

    countdown_timer_if #(.WIDTH(W)) bus_a ();
    countdown_timer_if #(.WIDTH(W)) bus_b ();

    assign bus_a.load_valid = load_valid;
    assign bus_a.load_value = load_value;
    assign bus_a.reload_en  = reload_en;
    assign bus_a.pause      = pause;
    assign bus_a.abort      = abort;
    assign bus_b.load_valid = load_valid;
    assign bus_b.load_value = load_value;
    assign bus_b.reload_en  = reload_en;
    assign bus_b.pause      = pause;
    assign bus_b.abort      = abort;

    countdown_timer #(.WIDTH(W), .PRESCALE(P_A)) dut_a (.clk(clk), .rstn(rstn), .bus(bus_a.slave));
    countdown_timer #(.WIDTH(W), .PRESCALE(P_B)) dut_b (.clk(clk), .rstn(rstn), .bus(bus_b.slave));

    always #5 clk = ~clk;

    logic [W-1:0] d_out   [2];
    logic         d_busy  [2];
    logic         d_done  [2];
    logic         d_ready [2];

    always_comb begin
        d_out[0]   = bus_a.out;
        d_out[1]   = bus_b.out;
        d_busy[0]  = bus_a.busy;
        d_busy[1]  = bus_b.busy;
        d_done[0]  = bus_a.done;
        d_done[1]  = bus_b.done;
        d_ready[0] = bus_a.load_ready;
        d_ready[1] = bus_b.load_ready;
    end

    // ---------------- reference model ----------------
    // Each instance is a budget of remaining clock cycles; the visible count
    // is that budget divided by the prescale, rounded up.
    bit   m_run [2];
    int   m_rem [2];
    int   m_rv  [2];
    exp_t sb_a[$];
    exp_t sb_b[$];

    function automatic int pre(input int d);
        return (d == 0) ? P_A : P_B;
    endfunction

    function automatic int exp_out(input int d);
        return m_run[d] ? (m_rem[d] + pre(d) - 1) / pre(d) : 0;
    endfunction

    function automatic void sb_push(input int d, input int stamp, input int value);
        exp_t e;
        e.stamp = stamp;
        e.out   = W'(value);
        if (d == 0) sb_a.push_back(e);
        else        sb_b.push_back(e);
    endfunction

    function automatic int sb_size(input int d);
        return (d == 0) ? sb_a.size() : sb_b.size();
    endfunction

    function automatic exp_t sb_pop(input int d);
        if (d == 0) return sb_a.pop_front();
        return sb_b.pop_front();
    endfunction

    function automatic exp_t sb_peek(input int d);
        if (d == 0) return sb_a[0];
        return sb_b[0];
    endfunction

    function automatic void model_reset();
        for (int d = 0; d < 2; d++) begin
            m_run[d] = 1'b0;
            m_rem[d] = 0;
            m_rv[d]  = 0;
        end
        sb_a.delete();
        sb_b.delete();
    endfunction

    // Apply one clock edge to the model using the inputs held across it.
    function automatic void model_edge(input int d);
        int p;
        p = pre(d);
        if (!m_run[d]) begin
            if (load_valid && !abort) begin
                if (load_value != '0) begin
                    m_run[d] = 1'b1;
                    m_rv[d]  = int'(load_value);
                    m_rem[d] = m_rv[d] * p;
                end else begin
                    sb_push(d, cycle, 0);
                end
            end
        end else if (abort) begin
            m_run[d] = 1'b0;
        end else if (!pause) begin
            m_rem[d]--;
            if (m_rem[d] == 0) begin
                if (reload_en) begin
                    m_rem[d] = m_rv[d] * p;
                    sb_push(d, cycle, m_rv[d]);
                end else begin
                    m_run[d] = 1'b0;
                    sb_push(d, cycle, 0);
                end
            end
        end
    endfunction

    // ---------------- checking ----------------
    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s @cycle %0d: got %0d expected %0d", name, cycle, act, exp);
        end
    endtask

    task automatic monitor_dut(input int d);
        exp_t e;
        check($sformatf("out_p%0d", pre(d)), 32'(d_out[d]), 32'(exp_out(d)));
        check($sformatf("busy_p%0d", pre(d)), 32'(d_busy[d]), 32'(m_run[d]));
        check($sformatf("ready_p%0d", pre(d)), 32'(d_ready[d]), 32'(!m_run[d] && !abort));
        if (d_done[d]) begin
            if (sb_size(d) == 0) begin
                total++;
                bad++;
                $display("FAIL done_unexpected_p%0d @cycle %0d: got done=1 expected done=0", pre(d), cycle);
            end else begin
                e = sb_pop(d);
                check($sformatf("done_cycle_p%0d", pre(d)), 32'(cycle), 32'(e.stamp));
                check($sformatf("done_out_p%0d", pre(d)), 32'(d_out[d]), 32'(e.out));
            end
        end else if (sb_size(d) > 0) begin
            e = sb_peek(d);
            if (e.stamp <= cycle) begin
                e = sb_pop(d);
                total++;
                bad++;
                $display("FAIL done_missing_p%0d @cycle %0d: got done=0 expected done=1 (due cycle %0d)",
                         pre(d), cycle, e.stamp);
            end
        end
    endtask

    // Monitor: compare both instances half a cycle after every edge.
    initial begin
        forever begin
            @(negedge clk);
            if (rstn) begin
                for (int d = 0; d < 2; d++) monitor_dut(d);
            end
        end
    end

    // ---------------- stimulus ----------------
    // Hold the given inputs across one rising edge, then advance the model.
    task automatic cyc(input logic lv, input logic [W-1:0] val, input logic re,
                       input logic pa, input logic ab);
        load_valid = lv;
        load_value = val;
        reload_en  = re;
        pause      = pa;
        abort      = ab;
        @(posedge clk);
        cycle++;
        if (rstn) begin
            for (int d = 0; d < 2; d++) model_edge(d);
        end
        #1;
    endtask

    task automatic idle(input int n, input logic re);
        for (int i = 0; i < n; i++) cyc(1'b0, '0, re, 1'b0, 1'b0);
    endtask

    initial begin
        int           done_at;
        int           pulses;
        logic         r_lv;
        logic [W-1:0] r_val;
        logic         r_re;
        logic         r_pa;
        logic         r_ab;

        model_reset();

        // Reset state, before any clock edge.
        #3;
        for (int d = 0; d < 2; d++) begin
            check("rst_out", 32'(d_out[d]), 32'd0);
            check("rst_busy", 32'(d_busy[d]), 32'd0);
            check("rst_done", 32'(d_done[d]), 32'd0);
        end
        @(posedge clk);
        #1;
        rstn = 1'b1;
        idle(3, 1'b0);

        // Load 5, no reload: 5,4,3,2,1 then expiry with out 0.
        cyc(1'b1, W'(5), 1'b0, 1'b0, 1'b0);
        check("l5_out_first", 32'(bus_a.out), 32'd5);
        for (int k = 4; k >= 1; k--) begin
            cyc(1'b0, '0, 1'b0, 1'b0, 1'b0);
            check("l5_out_step", 32'(bus_a.out), 32'(k));
        end
        cyc(1'b0, '0, 1'b0, 1'b0, 1'b0);
        check("l5_done", 32'(bus_a.done), 32'd1);
        check("l5_out_zero", 32'(bus_a.out), 32'd0);
        check("l5_busy_fall", 32'(bus_a.busy), 32'd0);
        check("l5_ready_back", 32'(bus_a.load_ready), 32'd1);
        idle(18, 1'b0);

        // Load 3 with reload on the divide-by-4 instance: pulses at 12/24/36.
        cyc(1'b1, W'(3), 1'b1, 1'b0, 1'b0);
        pulses = 0;
        for (int i = 1; i <= 36; i++) begin
            cyc(1'b0, '0, 1'b1, 1'b0, 1'b0);
            if (bus_b.done) pulses++;
            if (i % 12 == 0) begin
                check("rl_done_at", 32'(bus_b.done), 32'd1);
                check("rl_out_reload", 32'(bus_b.out), 32'd3);
            end
        end
        check("rl_pulses", 32'(pulses), 32'd3);
        check("rl_busy", 32'(bus_b.busy), 32'd1);
        cyc(1'b0, '0, 1'b0, 1'b0, 1'b1);

        // Load 10, pause 7 cycles at count 6: done 17 edges after acceptance.
        cyc(1'b1, W'(10), 1'b0, 1'b0, 1'b0);
        idle(4, 1'b0);
        check("ps_out_before", 32'(bus_a.out), 32'd6);
        for (int i = 0; i < 7; i++) begin
            cyc(1'b0, '0, 1'b0, 1'b1, 1'b0);
            check("ps_out_hold", 32'(bus_a.out), 32'd6);
        end
        done_at = -1;
        for (int i = 1; i <= 10; i++) begin
            cyc(1'b0, '0, 1'b0, 1'b0, 1'b0);
            if (bus_a.done && done_at < 0) done_at = 11 + i;
        end
        check("ps_latency", 32'(done_at), 32'd17);
        idle(40, 1'b0);

        // Load 8, abort at count 4; then abort blocks a concurrent load.
        cyc(1'b1, W'(8), 1'b0, 1'b0, 1'b0);
        idle(4, 1'b0);
        check("ab_out_before", 32'(bus_a.out), 32'd4);
        cyc(1'b0, '0, 1'b0, 1'b0, 1'b1);
        check("ab_out", 32'(bus_a.out), 32'd0);
        check("ab_busy", 32'(bus_a.busy), 32'd0);
        check("ab_done", 32'(bus_a.done), 32'd0);
        load_valid = 1'b1;
        load_value = W'(7);
        abort      = 1'b1;
        #1;
        check("ab_ready_a", 32'(bus_a.load_ready), 32'd0);
        check("ab_ready_b", 32'(bus_b.load_ready), 32'd0);
        cyc(1'b1, W'(7), 1'b0, 1'b0, 1'b1);
        check("ab_noload_busy", 32'(bus_a.busy), 32'd0);
        check("ab_noload_out", 32'(bus_a.out), 32'd0);
        cyc(1'b0, '0, 1'b0, 1'b0, 1'b0);
        check("ab_no_done", 32'(bus_a.done), 32'd0);

        // Zero load: immediate done, never busy.
        cyc(1'b1, '0, 1'b0, 1'b0, 1'b0);
        check("z_done_a", 32'(bus_a.done), 32'd1);
        check("z_done_b", 32'(bus_b.done), 32'd1);
        check("z_busy", 32'(bus_a.busy), 32'd0);
        cyc(1'b0, '0, 1'b0, 1'b0, 1'b0);
        check("z_done_once", 32'(bus_a.done), 32'd0);

        // Randomised traffic against the model.
        for (int i = 0; i < 3000; i++) begin
            r_lv  = ($urandom_range(0, 3) == 0);
            r_val = W'($urandom_range(0, 12));
            r_re  = $urandom_range(0, 1) == 1;
            r_pa  = ($urandom_range(0, 5) == 0);
            r_ab  = ($urandom_range(0, 39) == 0);
            cyc(r_lv, r_val, r_re, r_pa, r_ab);
        end
        cyc(1'b0, '0, 1'b0, 1'b0, 1'b1);
        idle(2, 1'b0);

        // Maximum load, then asynchronous reset between clock edges.
        cyc(1'b1, '1, 1'b0, 1'b0, 1'b0);
        idle(10, 1'b0);
        check("max_out_a", 32'(bus_a.out), 32'h000F_FFF5);
        check("max_out_b", 32'(bus_b.out), 32'h000F_FFFD);
        #1;
        rstn = 1'b0;
        model_reset();
        #1;
        for (int d = 0; d < 2; d++) begin
            check("arst_out", 32'(d_out[d]), 32'd0);
            check("arst_busy", 32'(d_busy[d]), 32'd0);
            check("arst_done", 32'(d_done[d]), 32'd0);
        end
        idle(2, 1'b0);
        rstn = 1'b1;
        idle(4, 1'b0);

        check("sb_empty_a", 32'(sb_size(0)), 32'd0);
        check("sb_empty_b", 32'(sb_size(1)), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
